// File: rtl/vend_ctrl.sv
//------------------------------------------------------------------------------
// Module  : vend_ctrl
// Purpose : Vending sequencer: coin/button edge events, credit, dispense and change phases.
//           Optional credit inactivity timeout when TIMEOUT_EN is defined.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vend_ctrl #(
    parameter logic [7:0]  PRICE          = 8'd75,
    parameter logic [7:0]  MAX_CREDIT     = 8'd100,
    parameter int unsigned DISP_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
    input  logic       CLK50M,
    input  logic       reset,
    input  logic       nickel,
    input  logic       dime,
    input  logic       quarter,
    input  logic       select,
    input  logic       cancel,
    output logic [7:0] credit,
    output logic       dispense,
    output logic       change_valid,
    output logic [7:0] change,
    output logic       coin_reject,
    output logic [3:0] state_led
);

    // One-hot encoding so the state register drives the LEDs directly.
    typedef enum logic [3:0] {
        S_IDLE     = 4'b0001,
        S_CREDIT   = 4'b0010,
        S_DISPENSE = 4'b0100,
        S_CHANGE   = 4'b1000
    } state_t;

    localparam logic [28:0] DISP_LAST = 29'(DISP_CYCLES - 1);
    localparam logic [28:0] TO_LAST   = 29'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  prev_q;
    logic [7:0]  credit_q, credit_d;
    logic [7:0]  amt_q, amt_d;
    logic [7:0]  change_q, change_d;
    logic        reject_q, reject_d;
    logic [28:0] cnt_q, cnt_d;

    logic [4:0]  w_level;
    logic [4:0]  w_rise;
    logic        w_ev_cancel;
    logic        w_ev_select;
    logic        w_ev_coin;
    logic [7:0]  w_coin_val;
    logic [8:0]  w_sum;
    logic        w_coin_ok;
    logic        w_timeout;

    assign w_level = {cancel, select, quarter, dime, nickel};
    assign w_rise  = w_level & ~prev_q;

    assign w_ev_cancel = w_rise[4];
    assign w_ev_select = w_rise[3] & ~w_rise[4];
    assign w_ev_coin   = (w_rise[2:0] != 3'b000) && (w_rise[4:3] == 2'b00);
    assign w_coin_val  = w_rise[2] ? 8'd25 : (w_rise[1] ? 8'd10 : 8'd5);
    assign w_sum       = {1'b0, credit_q} + {1'b0, w_coin_val};
    assign w_coin_ok   = (w_sum <= {1'b0, MAX_CREDIT});

`ifdef TIMEOUT_EN
    assign w_timeout = (cnt_q == TO_LAST);
`else
    logic w_unused_timeout;
    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^TO_LAST;
`endif

    always_ff @(posedge CLK50M) begin
        if (reset) begin
            state_q  <= S_IDLE;
            prev_q   <= 5'b11111;
            credit_q <= 8'd0;
            amt_q    <= 8'd0;
            change_q <= 8'd0;
            reject_q <= 1'b0;
            cnt_q    <= 29'd0;
        end else begin
            state_q  <= state_d;
            prev_q   <= w_level;
            credit_q <= credit_d;
            amt_q    <= amt_d;
            change_q <= change_d;
            reject_q <= reject_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        amt_d    = amt_q;
        change_d = change_q;
        reject_d = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_ev_coin) begin
                    if (w_coin_ok) begin
                        state_d  = S_CREDIT;
                        credit_d = w_sum[7:0];
                        cnt_d    = 29'd0;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_CREDIT: begin
                if (w_ev_select && (credit_q >= PRICE)) begin
                    amt_d    = credit_q - PRICE;
                    credit_d = 8'd0;
                    state_d  = S_DISPENSE;
                    cnt_d    = DISP_LAST;
                end else if (w_ev_coin && w_coin_ok) begin
                    credit_d = w_sum[7:0];
                    cnt_d    = 29'd0;
                end else if (w_ev_cancel || (!w_ev_select && !w_ev_coin && w_timeout)) begin
                    amt_d    = credit_q;
                    change_d = credit_q;
                    credit_d = 8'd0;
                    state_d  = S_CHANGE;
                    cnt_d    = DISP_LAST;
                end else begin
                    reject_d = w_ev_coin;
`ifdef TIMEOUT_EN
                    cnt_d    = cnt_q + 29'd1;
`endif
                end
            end
            S_DISPENSE: begin
                reject_d = w_ev_coin;
                if (cnt_q == 29'd0) begin
                    if (amt_q != 8'd0) begin
                        state_d  = S_CHANGE;
                        change_d = amt_q;
                        cnt_d    = DISP_LAST;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 29'd1;
                end
            end
            S_CHANGE: begin
                reject_d = w_ev_coin;
                if (cnt_q == 29'd0) begin
                    state_d  = S_IDLE;
                    change_d = 8'd0;
                    amt_d    = 8'd0;
                end else begin
                    cnt_d = cnt_q - 29'd1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = 8'd0;
                amt_d    = 8'd0;
                change_d = 8'd0;
                cnt_d    = 29'd0;
            end
        endcase
    end

    assign credit       = credit_q;
    assign dispense     = state_q[2];
    assign change_valid = state_q[3];
    assign change       = change_q;
    assign coin_reject  = reject_q;
    assign state_led    = state_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_vend_ctrl
// Purpose : Directed and random stimulus for vend_ctrl against a transaction-level model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vend_ctrl;

    localparam int PRICE_C = 75;
    localparam int MAXC_C  = 100;
    localparam int DISP_C  = 4;
    localparam int TO_C    = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       nickel = 1'b0, dime = 1'b0, quarter = 1'b0, select = 1'b0, cancel = 1'b0;
    logic [7:0] credit, change;
    logic       dispense, change_valid, coin_reject;
    logic [3:0] state_led;

    int checks   = 0;
    int failures = 0;

    // Model: machine mode 0 idle, 1 credit, 2 dispense, 3 change.
    int         m_mode, m_credit, m_pending, m_change, m_left, m_idle;
    logic       m_reject;
    logic [4:0] m_prev;

    vend_ctrl #(
        .PRICE(8'd75), .MAX_CREDIT(8'd100),
        .DISP_CYCLES(DISP_C), .TIMEOUT_CYCLES(TO_C)
    ) dut (
        .CLK50M(clk), .reset(reset),
        .nickel(nickel), .dime(dime), .quarter(quarter),
        .select(select), .cancel(cancel),
        .credit(credit), .dispense(dispense), .change_valid(change_valid),
        .change(change), .coin_reject(coin_reject), .state_led(state_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_credit = 0; m_pending = 0; m_change = 0;
        m_left = 0; m_idle = 0; m_reject = 1'b0; m_prev = 5'b11111;
    endtask

    task automatic refund(input int amount);
        m_pending = amount; m_change = amount; m_credit = 0;
        m_mode = 3; m_left = DISP_C;
    endtask

    task automatic model_step(input logic [4:0] lv);
        logic [4:0] r;
        int         coin;
        bit         ev_c, ev_s;
        r    = lv & ~m_prev;
        m_prev = lv;
        ev_c = r[4];
        ev_s = r[3] && !r[4];
        coin = 0;
        if (r[4:3] == 2'b00)
            coin = r[2] ? 25 : (r[1] ? 10 : (r[0] ? 5 : 0));
        m_reject = 1'b0;
        case (m_mode)
            0: if (coin != 0) begin
                   if (coin <= MAXC_C) begin m_mode = 1; m_credit = coin; m_idle = 0; end
                   else m_reject = 1'b1;
               end
            1: begin
                   if (ev_s && m_credit >= PRICE_C) begin
                       m_pending = m_credit - PRICE_C; m_credit = 0;
                       m_mode = 2; m_left = DISP_C;
                   end else if (coin != 0 && m_credit + coin <= MAXC_C) begin
                       m_credit += coin; m_idle = 0;
                   end else if (ev_c) begin
                       refund(m_credit);
                   end else begin
                       m_reject = (coin != 0);
`ifdef TIMEOUT_EN
                       if (!ev_s && coin == 0 && m_idle + 1 == TO_C) refund(m_credit);
                       else m_idle++;
`endif
                   end
               end
            2: begin
                   m_reject = (coin != 0);
                   m_left--;
                   if (m_left == 0) begin
                       if (m_pending != 0) begin
                           m_mode = 3; m_change = m_pending; m_left = DISP_C;
                       end else m_mode = 0;
                   end
               end
            default: begin
                   m_reject = (coin != 0);
                   m_left--;
                   if (m_left == 0) begin m_mode = 0; m_change = 0; m_pending = 0; end
               end
        endcase
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare everything after it.
    task automatic tick(input logic [4:0] lv, input logic rst_v);
        @(negedge clk);
        {cancel, select, quarter, dime, nickel} = lv;
        reset = rst_v;
        @(posedge clk);
        if (rst_v) model_reset();
        else model_step(lv);
        #1;
        check("credit",       {24'd0, credit},       m_credit);
        check("dispense",     {31'd0, dispense},     (m_mode == 2) ? 1 : 0);
        check("change_valid", {31'd0, change_valid}, (m_mode == 3) ? 1 : 0);
        check("change",       {24'd0, change},       m_change);
        check("coin_reject",  {31'd0, coin_reject},  {31'd0, m_reject});
        check("state_led",    {28'd0, state_led},    32'd1 << m_mode);
    endtask

    task automatic pulse(input logic [4:0] lv);
        tick(lv, 1'b0);
        tick(5'b00000, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(5'b00000, 1'b0);
    endtask

    localparam logic [4:0] NK = 5'b00001, DM = 5'b00010, QT = 5'b00100,
                           SL = 5'b01000, CN = 5'b10000;

    initial begin
        model_reset();
        // Quarter held through reset release must not count as a coin.
        tick(QT, 1'b1);
        tick(QT, 1'b1);
        check("rst_led", {28'd0, state_led}, 32'd1);
        tick(QT, 1'b0);
        check("held_no_event", {24'd0, credit}, 32'd0);
        tick(5'b00000, 1'b0);

        // Exact price
        pulse(QT); check("exact_c25", {24'd0, credit}, 32'd25);
        pulse(QT); check("exact_c50", {24'd0, credit}, 32'd50);
        pulse(QT); check("exact_c75", {24'd0, credit}, 32'd75);
        tick(SL, 1'b0);
        check("exact_disp", {31'd0, dispense}, 32'd1);
        idle(6);
        check("exact_idle", {28'd0, state_led}, 32'd1);

        // Overpay
        for (int i = 0; i < 4; i++) pulse(QT);
        check("over_c100", {24'd0, credit}, 32'd100);
        pulse(SL);
        idle(3);
        check("over_cv", {31'd0, change_valid}, 32'd1);
        check("over_chg", {24'd0, change}, 32'd25);
        idle(6);

        // Ceiling
        for (int i = 0; i < 4; i++) pulse(QT);
        tick(NK, 1'b0);
        check("ceil_rej", {31'd0, coin_reject}, 32'd1);
        check("ceil_c100", {24'd0, credit}, 32'd100);
        tick(5'b00000, 1'b0);
        check("ceil_rej_off", {31'd0, coin_reject}, 32'd0);
        pulse(CN);
        idle(6);

        // Simultaneous edges
        pulse(DM | NK);
        check("simul_c10", {24'd0, credit}, 32'd10);
        pulse(QT); pulse(QT); pulse(DM); pulse(DM);
        check("simul_c80", {24'd0, credit}, 32'd80);
        tick(CN | SL, 1'b0);
        check("simul_cv", {31'd0, change_valid}, 32'd1);
        check("simul_chg", {24'd0, change}, 32'd80);
        check("simul_nodisp", {31'd0, dispense}, 32'd0);
        tick(5'b00000, 1'b0);
        idle(5);

        // Underpay, reject during dispense, reset mid-dispense
        pulse(DM);
        pulse(SL);
        check("under_c10", {24'd0, credit}, 32'd10);
        check("under_nodisp", {31'd0, dispense}, 32'd0);
        pulse(QT); pulse(QT); pulse(QT);
        pulse(SL);
        tick(QT, 1'b0);
        check("disp_rej", {31'd0, coin_reject}, 32'd1);
        tick(5'b00000, 1'b1);
        check("mid_rst_disp", {31'd0, dispense}, 32'd0);
        check("mid_rst_led", {28'd0, state_led}, 32'd1);
        tick(5'b00000, 1'b0);

        // Timeout
        pulse(DM);
`ifdef TIMEOUT_EN
        idle(18);
        check("to_pending", {31'd0, change_valid}, 32'd0);
        idle(1);
        check("to_cv", {31'd0, change_valid}, 32'd1);
        check("to_chg", {24'd0, change}, 32'd10);
        idle(6);
`else
        idle(100);
        check("no_to_c10", {24'd0, credit}, 32'd10);
        pulse(CN);
        idle(6);
`endif

        // Random levels with occasional reset
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] lv;
            lv[0] = ($urandom_range(0, 99) < 35);
            lv[1] = ($urandom_range(0, 99) < 30);
            lv[2] = ($urandom_range(0, 99) < 30);
            lv[3] = ($urandom_range(0, 99) < 12);
            lv[4] = ($urandom_range(0, 99) < 3);
            tick(lv, ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vend_ctrl.md
# vend_ctrl

Vending-machine sequencer for the FSM_Vending design. It runs on the 50 MHz board clock and takes debounced coin and button levels, each from its own debouncer instance. It converts those levels into single-cycle events, accumulates credit, and sequences dispense and change-return phases. Its outputs drive the board LEDs directly.

## Interface
- PRICE, 8'd75: item price in cents; must be a nonzero multiple of 5 and ≤ MAX_CREDIT.
- MAX_CREDIT, 8'd100: credit ceiling in cents; must be ≤ 255.
- DISP_CYCLES, 50_000_000: hold length of the dispense and change phases, in cycles (1 s at 50 MHz).
- TIMEOUT_CYCLES, 500_000_000: credit inactivity limit in cycles; used only with TIMEOUT_EN.
- CLK50M  in  1  board clock; the only clock.
- reset  in  1  synchronous, active-high; sampled on the CLK50M rising edge.
- nickel, dime, quarter  in  1 each  debounced coin levels; a rising edge is one coin of 5, 10 or 25 cents.
- select  in  1  debounced level; a rising edge is a purchase request.
- cancel  in  1  debounced level; a rising edge is a refund request.
- credit  out  8  current credit in cents.
- dispense  out  1  high for the whole DISPENSE phase.
- change_valid  out  1  high for the whole CHANGE phase.
- change  out  8  refund amount in cents; held while change_valid is high, 0 otherwise.
- coin_reject  out  1  one-cycle pulse when a coin is refused.
- state_led  out  4  one-hot state indicator: [0] IDLE, [1] CREDIT, [2] DISPENSE, [3] CHANGE.

## Operation
- Edge detection:
  - Each input is compared against a registered copy of its previous level.
  - The previous-level registers reset to 1, so an input already held high at reset release never produces an event.
- One event per cycle, in this priority order: cancel > select > quarter > dime > nickel.
  - Lower-priority edges in the same cycle are dropped.
  - A dropped coin produces no reject pulse.
- Arithmetic:
  - credit + coin value is computed in 9 bits.
  - A coin is accepted only if the sum is ≤ MAX_CREDIT; otherwise coin_reject pulses and credit is unchanged.
- States:
  - IDLE: credit = 0. A coin moves to CREDIT with credit = value. select and cancel are ignored.
  - CREDIT:
    - Coin: credit is updated per the arithmetic rule.
    - select with credit ≥ PRICE: latch change = credit − PRICE, clear credit to 0, go to DISPENSE.
    - select with credit < PRICE: ignored; state and credit unchanged.
    - cancel: latch change = credit, clear credit to 0, go to CHANGE.
  - DISPENSE:
    - dispense = 1 for exactly DISP_CYCLES cycles.
    - Then go to CHANGE if the latched change ≠ 0, else IDLE.
    - Every coin edge pulses coin_reject; select and cancel are ignored.
  - CHANGE:
    - change_valid = 1 and change is driven for exactly DISP_CYCLES cycles.
    - Then change clears to 0 and the block returns to IDLE.
    - Coins are rejected; select and cancel are ignored.
- Reset behaviour, at power-up or mid-operation:
  - State goes to IDLE and credit, change, dispense, change_valid and coin_reject all go to 0.
  - state_led = 4'b0001.
  - The phase counter clears and any in-flight credit is discarded.

## Timing
- All outputs are registered.
- An input sampled high at edge k after being low at edge k−1 takes effect at edge k:
  - credit, coin_reject and state_led reflect the event from edge k onward.
  - coin_reject is high for exactly the one cycle following edge k.
- dispense rises at the edge that samples the select event and stays high DISP_CYCLES cycles.
- change_valid follows dispense with no gap cycle.
- A cancel event raises change_valid at the sampling edge.
- A level held high produces exactly one event; the next event requires a low sample first.
- The phase counter is 29 bits wide and reloads on every state entry.

## Configuration
- TIMEOUT_EN defined:
  - In CREDIT, a counter increments every cycle and clears on every accepted coin.
  - When it reaches TIMEOUT_CYCLES, the block behaves as on cancel: change = credit, credit = 0, go to CHANGE.
- TIMEOUT_EN undefined:
  - There is no timeout counter; CREDIT holds indefinitely.
  - TIMEOUT_CYCLES is unused.

## Test plan
Bench parameters: DISP_CYCLES=4, TIMEOUT_CYCLES=20.
- Exact price: reset, quarter ×3, select -> credit 25/50/75, then dispense high 4 cycles, change_valid never asserts, state returns to IDLE with credit 0.
- Overpay: quarter ×4 (credit 100), select -> dispense 4 cycles, then change_valid 4 cycles with change=25, then IDLE.
- Ceiling: quarter ×4, then nickel -> coin_reject high for 1 cycle, credit stays 100.
- Simultaneous events:
  - dime and nickel edges in the same cycle -> credit 10.
  - Then with credit 80, cancel and select edges in the same cycle -> CHANGE with change=80, no dispense.
- Underpay, rejection and reset: dime, select -> credit stays 10, no dispense. Then during DISPENSE:
  - a quarter edge -> coin_reject pulses;
  - reset asserted -> all outputs 0 and state_led=0001 after that edge.
- Timeout:
  - With TIMEOUT_EN, dime then 20 idle cycles -> change_valid with change=10.
  - Without TIMEOUT_EN, credit holds 10 for 100 cycles.
